// File: rtl/gemv_arith_core.sv
// GEMV arithmetic core: a signed PE multiplier, a reciprocal-scale divider FSM and a 3-stage requantizer.
// Build option: define QUANT_SYMMETRIC_CLAMP_EN to clamp quantized output symmetrically to [-QMAX, QMAX].
module gemv_arith_core #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     pe_w,
  input  logic [DATA_WIDTH-1:0]     pe_x,
  output logic [2*DATA_WIDTH-1:0]   pe_y,
  input  logic [4*DATA_WIDTH-1:0]   max_abs,
  input  logic                      sc_start,
  output logic [4*DATA_WIDTH-1:0]   recip_scale,
  output logic                      sc_ready,
  input  logic [4*DATA_WIDTH-1:0]   q_in,
  input  logic                      q_valid_in,
  output logic [DATA_WIDTH-1:0]     q_out,
  output logic                      q_valid_out
);

  localparam int W      = 4 * DATA_WIDTH;
  localparam int PW     = 2 * W;
  localparam int CW     = $clog2(W + 1);
  localparam int QMAX_I = (1 << (DATA_WIDTH - 1)) - 1;

  localparam logic [W-1:0]         DIVIDEND = W'(QMAX_I) << FRAC_BITS;
  localparam logic [CW-1:0]        LAST_CNT = CW'(W);
  localparam logic [PW-1:0]        ROUND_C  = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [PW-1:0] SAT_HI   = PW'(QMAX_I);
`ifdef QUANT_SYMMETRIC_CLAMP_EN
  localparam logic signed [PW-1:0] SAT_LO   = -SAT_HI;
`else
  localparam logic signed [PW-1:0] SAT_LO   = -SAT_HI - PW'(1);
`endif

  // ---------------------------------------------------------------- PE
  logic signed [2*DATA_WIDTH-1:0] pe_w_ext;
  logic signed [2*DATA_WIDTH-1:0] pe_x_ext;
  logic        [2*DATA_WIDTH-1:0] pe_y_reg;

  assign pe_w_ext = {{DATA_WIDTH{pe_w[DATA_WIDTH-1]}}, pe_w};
  assign pe_x_ext = {{DATA_WIDTH{pe_x[DATA_WIDTH-1]}}, pe_x};

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_y_reg <= '0;
    end else begin
      pe_y_reg <= pe_w_ext * pe_x_ext;
    end
  end

  assign pe_y = pe_y_reg;

  // ---------------------------------------------------------------- Scale divider
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} sc_state_t;

  sc_state_t      sc_state_reg;
  logic [W-1:0]   div_d_reg;
  logic [W-1:0]   div_rem_reg;
  logic [W-1:0]   div_quo_reg;
  logic [CW-1:0]  div_cnt_reg;
  logic [W-1:0]   recip_reg;
  logic           ready_reg;

  logic [W:0]     rem_shift;
  logic [W-1:0]   div_rem_next;
  logic [W-1:0]   div_quo_next;
  logic           div_d_nonpos;

  assign div_d_nonpos = max_abs[W-1] || (max_abs == '0);

  // Remainder stays below D, so the subtraction result always fits in W bits.
  always_comb begin
    rem_shift    = {div_rem_reg, div_quo_reg[W-1]};
    div_rem_next = rem_shift[W-1:0];
    div_quo_next = {div_quo_reg[W-2:0], 1'b0};
    if (rem_shift >= {1'b0, div_d_reg}) begin
      div_rem_next = rem_shift[W-1:0] - div_d_reg;
      div_quo_next = {div_quo_reg[W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_state_reg <= IDLE;
      div_d_reg    <= '0;
      div_rem_reg  <= '0;
      div_quo_reg  <= '0;
      div_cnt_reg  <= '0;
      recip_reg    <= '0;
      ready_reg    <= 1'b0;
    end else begin
      case (sc_state_reg)
        IDLE: begin
          if (sc_start) begin
            sc_state_reg <= DIVIDE;
            div_d_reg    <= div_d_nonpos ? W'(1) : max_abs;
            div_rem_reg  <= '0;
            div_quo_reg  <= DIVIDEND;
            div_cnt_reg  <= '0;
          end
        end
        DIVIDE: begin
          // W iteration cycles, then one load cycle: result lands W+1 edges after start.
          if (div_cnt_reg == LAST_CNT) begin
            recip_reg    <= div_quo_reg;
            ready_reg    <= 1'b1;
            sc_state_reg <= DONE;
          end else begin
            div_rem_reg <= div_rem_next;
            div_quo_reg <= div_quo_next;
            div_cnt_reg <= div_cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (!sc_start) begin
            ready_reg    <= 1'b0;
            sc_state_reg <= IDLE;
          end
        end
        default: begin
          sc_state_reg <= IDLE;
          ready_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign recip_scale = recip_reg;
  assign sc_ready    = ready_reg;

  // ---------------------------------------------------------------- Quantizer
  logic signed [PW-1:0]         q_in_ext;
  logic signed [PW-1:0]         recip_ext;
  logic signed [PW-1:0]         s1_prod_reg;
  logic signed [PW-1:0]         s2_round_reg;
  logic        [DATA_WIDTH-1:0] s3_q_reg;
  logic        [DATA_WIDTH-1:0] s3_q_next;
  logic        [2:0]            qv_reg;

  assign q_in_ext  = {{W{q_in[W-1]}}, q_in};
  assign recip_ext = {{W{1'b0}}, recip_reg};

  always_comb begin
    s3_q_next = s2_round_reg[DATA_WIDTH-1:0];
    if (s2_round_reg > SAT_HI) begin
      s3_q_next = SAT_HI[DATA_WIDTH-1:0];
    end else if (s2_round_reg < SAT_LO) begin
      s3_q_next = SAT_LO[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_prod_reg  <= '0;
      s2_round_reg <= '0;
      s3_q_reg     <= '0;
    end else begin
      s1_prod_reg  <= q_in_ext * recip_ext;
      s2_round_reg <= (s1_prod_reg + $signed(ROUND_C)) >>> FRAC_BITS;
      s3_q_reg     <= s3_q_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_qv
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) qv_reg[gi] <= 1'b0;
          else     qv_reg[gi] <= q_valid_in;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) qv_reg[gi] <= 1'b0;
          else     qv_reg[gi] <= qv_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q_out       = s3_q_reg;
  assign q_valid_out = qv_reg[2];

endmodule

// File: tb/tb_gemv_arith_core.sv
// Self-checking bench for gemv_arith_core: directed and random steps against a plain-arithmetic reference model.
module tb_gemv_arith_core;

  localparam int DW   = 8;
  localparam int FRAC = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   pe_w, pe_x;
  logic [2*DW-1:0] pe_y;
  logic [31:0]     max_abs;
  logic            sc_start;
  logic [31:0]     recip_scale;
  logic            sc_ready;
  logic [31:0]     q_in;
  logic            q_valid_in;
  logic [DW-1:0]   q_out;
  logic            q_valid_out;

  int checks = 0;
  int errors = 0;

  longint cur_recip;
  bit     exp_v[$];
  longint exp_q[$];

  gemv_arith_core #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst(rst),
    .pe_w(pe_w), .pe_x(pe_x), .pe_y(pe_y),
    .max_abs(max_abs), .sc_start(sc_start), .recip_scale(recip_scale), .sc_ready(sc_ready),
    .q_in(q_in), .q_valid_in(q_valid_in), .q_out(q_out), .q_valid_out(q_valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  function automatic longint recip_ref(input logic [31:0] m);
    longint d;
    d = longint'($signed(m));
    if (d <= 0) d = 1;
    return (longint'(127) << FRAC) / d;
  endfunction

  function automatic longint quant_ref(input logic [31:0] q, input longint recip);
    longint p, r, lo;
    p = longint'($signed(q)) * recip;
    r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef QUANT_SYMMETRIC_CLAMP_EN
    lo = -127;
`else
    lo = -128;
`endif
    if (r > 127) r = 127;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Counts negedges until sc_ready; the edge that samples sc_start is negedge 1, so +33 edges reads as 34.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (sc_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_scale(input logic [31:0] m, input bit drop_early);
    int lat;
    longint expr;
    expr = recip_ref(m);
    @(negedge clk);
    max_abs  = m;
    sc_start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (drop_early && i == 5) sc_start = 1'b0;
      if (sc_ready) begin
        lat = i;
        break;
      end
    end
    chk("sc_latency", lat, 34);
    chk("recip_scale", longint'(recip_scale), expr);
    $display("scale max_abs=%0d recip=%0d latency=%0d", $signed(m), recip_scale, lat);
    if (!drop_early) begin
      @(negedge clk);
      chk("sc_ready_hold", sc_ready, 1);
      chk("recip_hold", longint'(recip_scale), expr);
      sc_start = 1'b0;
    end
    @(negedge clk);
    chk("sc_ready_drop", sc_ready, 0);
    chk("recip_keep", longint'(recip_scale), expr);
    cur_recip = expr;
  endtask

  // One negedge step of the quantizer stream; compares the item driven three steps earlier.
  task automatic tick(input bit v, input logic [31:0] q);
    bit ev;
    longint eq;
    @(negedge clk);
    if (exp_v.size() == 3) begin
      ev = exp_v.pop_front();
      eq = exp_q.pop_front();
      chk("q_valid_out", q_valid_out, ev);
      if (ev) begin
        chk("q_out", longint'($signed(q_out)), eq);
        $display("quant recip=%0d q_out=%0d expected=%0d", cur_recip, $signed(q_out), eq);
      end
    end
    q_valid_in = v;
    q_in       = q;
    exp_v.push_back(v);
    exp_q.push_back(quant_ref(q, cur_recip));
  endtask

  task automatic drain();
    repeat (3) tick(1'b0, 32'd0);
    exp_v.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0] w, x;
    logic [31:0]   m;
    int            lat;
    bit            seen;
    longint        expr;

    rst = 1'b1; pe_w = '0; pe_x = '0; max_abs = '0; sc_start = 1'b0;
    q_in = '0; q_valid_in = 1'b0; cur_recip = 0;
    repeat (2) @(negedge clk);
    chk("rst_pe_y", longint'(pe_y), 0);
    chk("rst_recip", longint'(recip_scale), 0);
    chk("rst_sc_ready", sc_ready, 0);
    chk("rst_q_out", longint'(q_out), 0);
    chk("rst_q_valid_out", q_valid_out, 0);
    rst = 1'b0;

    // PE: corner products then random operands
    pe_w = 8'h80; pe_x = 8'h80;
    @(negedge clk);
    chk("pe_min_min", longint'($signed(pe_y)), 16384);
    pe_w = 8'd5; pe_x = 8'hFD;
    @(negedge clk);
    chk("pe_5_m3", longint'($signed(pe_y)), -15);
    for (int i = 0; i < 20; i++) begin
      w = DW'($urandom); x = DW'($urandom);
      pe_w = w; pe_x = x;
      @(negedge clk);
      chk("pe_rand", longint'($signed(pe_y)), longint'($signed(w)) * longint'($signed(x)));
      $display("pe w=%0d x=%0d y=%0d", $signed(w), $signed(x), $signed(pe_y));
    end

    // Scale 127 -> 65536, then directed quantization
    run_scale(32'd127, 1'b0);
    drain();
    tick(1'b1, 32'd100);
    tick(1'b1, 32'd300);
    tick(1'b1, -32'sd300);
    tick(1'b0, 32'd7);
    for (int i = 1; i <= 5; i++) tick(1'b1, 32'(i));
    drain();

    // Scale 254 -> 32768, half-up rounding cases
    run_scale(32'd254, 1'b0);
    tick(1'b1, 32'd3);
    tick(1'b1, -32'sd3);
    tick(1'b1, 32'd1);
    drain();

    // Non-positive divisors, and sc_start dropped mid-division
    run_scale(32'd0, 1'b0);
    run_scale(-32'sd5, 1'b1);

    // Random scales with random quantization traffic
    for (int r = 0; r < 3; r++) begin
      m = 32'($urandom_range(1, 100000));
      run_scale(m, r == 1);
      for (int i = 0; i < 12; i++) tick(1'($urandom), $urandom);
      drain();
    end

    // Reset one cycle after a valid sample: nothing may emerge
    @(negedge clk);
    q_valid_in = 1'b1; q_in = 32'd5;
    @(negedge clk);
    q_valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (q_valid_out) seen = 1'b1;
    end
    chk("rst_pipe_no_valid", seen, 0);
    chk("rst_pipe_q_out", longint'(q_out), 0);

    // Reset at cycle 10 of a division with sc_start held: restart and finish
    run_scale(32'd127, 1'b0);
    @(negedge clk);
    m = 32'd254;
    expr = recip_ref(m);
    max_abs = m; sc_start = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_div_sc_ready", sc_ready, 0);
    chk("rst_div_recip", longint'(recip_scale), 0);
    wait_ready(lat);
    chk("restart_latency", lat, 34);
    chk("restart_recip", longint'(recip_scale), expr);
    $display("restart recip=%0d latency=%0d", recip_scale, lat);
    sc_start = 1'b0;
    @(negedge clk);
    chk("restart_drop", sc_ready, 0);
    cur_recip = expr;
    tick(1'b1, 32'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
